pe_bypass_scb: RTL

//  Parametrised PE operand-bypass network with an internal forwarding history and a load-use scoreboard.

---
 rtl/pe_bypass_scb_if.sv | 47 ++++
 rtl/pe_bypass_scb.sv | 133 +++++++++++++
 2 files changed

// File: rtl/pe_bypass_scb_if.sv
// Bundle of ID-side operand, writeback/load-return and neighbour signals for the PE bypass block.
interface pe_bypass_scb_if #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned RF_INDEX_WIDTH = 5,
  parameter int unsigned CNT_WIDTH      = 16
);
  logic                      stall;
  logic                      ex_we;
  logic [RF_INDEX_WIDTH-1:0] ex_addr;
  logic [DATA_WIDTH-1:0]     ex_data;
  logic                      ex_is_load;
  logic                      ld_valid;
  logic [RF_INDEX_WIDTH-1:0] ld_addr;
  logic [DATA_WIDTH-1:0]     ld_data;
  logic [RF_INDEX_WIDTH-1:0] rd_addr_a;
  logic [RF_INDEX_WIDTH-1:0] rd_addr_b;
  logic [DATA_WIDTH-1:0]     rf_data_a;
  logic [DATA_WIDTH-1:0]     rf_data_b;
  logic                      sel_imm;
  logic [DATA_WIDTH-1:0]     imm;
  logic                      is_sub;
  logic [1:0]                data_sel;
  logic [DATA_WIDTH-1:0]     left_data;
  logic [DATA_WIDTH-1:0]     right_data;
  logic [DATA_WIDTH-1:0]     cp_data;
  logic [DATA_WIDTH-1:0]     operand_a;
  logic [DATA_WIDTH-1:0]     operand_b;
  logic [DATA_WIDTH-1:0]     store_data;
  logic [DATA_WIDTH-1:0]     port1_data;
  logic                      hazard_stall;
  logic                      late_error;
  logic [CNT_WIDTH-1:0]      stall_count;

  modport master (
    output stall, ex_we, ex_addr, ex_data, ex_is_load, ld_valid, ld_addr, ld_data,
    output rd_addr_a, rd_addr_b, rf_data_a, rf_data_b, sel_imm, imm, is_sub, data_sel,
    output left_data, right_data, cp_data,
    input  operand_a, operand_b, store_data, port1_data, hazard_stall, late_error, stall_count
  );

  modport slave (
    input  stall, ex_we, ex_addr, ex_data, ex_is_load, ld_valid, ld_addr, ld_data,
    input  rd_addr_a, rd_addr_b, rf_data_a, rf_data_b, sel_imm, imm, is_sub, data_sel,
    input  left_data, right_data, cp_data,
    output operand_a, operand_b, store_data, port1_data, hazard_stall, late_error, stall_count
  );
endinterface

// File: rtl/pe_bypass_scb.sv
// PE operand-bypass network: forwarding history with load-use scoreboard, neighbour/immediate
// selection and RSUBI swap.
module pe_bypass_scb #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned RF_INDEX_WIDTH = 5,
  parameter int unsigned FWD_DEPTH      = 3,
  parameter int unsigned ZERO_REGS      = 2,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input logic            clk,
  input logic            rst_n,
  pe_bypass_scb_if.slave bus
);
  typedef logic [DATA_WIDTH-1:0]     data_t;
  typedef logic [RF_INDEX_WIDTH-1:0] addr_t;

  logic [FWD_DEPTH-1:0] en_q, en_d, rdy_q, rdy_d;
  addr_t                addr_q [FWD_DEPTH];
  addr_t                addr_d [FWD_DEPTH];
  data_t                data_q [FWD_DEPTH];
  data_t                data_d [FWD_DEPTH];
  logic                 late_q, late_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  addr_t      rd_addr [2];
  data_t      rf_data [2];
  data_t      fwd     [2];
  logic [1:0] pend;
  data_t      a_sel, b_sel;
  logic       swap, hazard;

  always_comb begin
    en_d   = en_q;
    rdy_d  = rdy_q;
    addr_d = addr_q;
    data_d = data_q;
    if (!bus.stall) begin
      en_d[0]   = bus.ex_we;
      addr_d[0] = bus.ex_addr;
      data_d[0] = bus.ex_data;
      rdy_d[0]  = ~bus.ex_is_load;
      for (int k = 1; k < FWD_DEPTH; k++) begin
        en_d[k]   = en_q[k-1];
        addr_d[k] = addr_q[k-1];
        data_d[k] = data_q[k-1];
        rdy_d[k]  = rdy_q[k-1];
      end
    end
    // Fills act on post-shift positions; a freshly written entry 0 is never filled.
    for (int k = 0; k < FWD_DEPTH; k++) begin
      if (bus.ld_valid && en_d[k] && !rdy_d[k] && (addr_d[k] == bus.ld_addr) &&
          (k != 0 || bus.stall)) begin
        rdy_d[k]  = 1'b1;
        data_d[k] = bus.ld_data;
      end
    end
  end

  assign late_d = late_q | (!bus.stall && en_q[FWD_DEPTH-1] && !rdy_q[FWD_DEPTH-1]);

  assign rd_addr[0] = bus.rd_addr_a;
  assign rd_addr[1] = bus.rd_addr_b;
  assign rf_data[0] = bus.rf_data_a;
  assign rf_data[1] = bus.rf_data_b;

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      fwd[p]  = rf_data[p];
      pend[p] = 1'b0;
      for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
        if (en_q[k] && (addr_q[k] == rd_addr[p])) begin
          if (rdy_q[k]) begin
            fwd[p]  = data_q[k];
            pend[p] = 1'b0;
          end else if (bus.ld_valid && (bus.ld_addr == rd_addr[p])) begin
            fwd[p]  = bus.ld_data;
            pend[p] = 1'b0;
          end else begin
            fwd[p]  = rf_data[p];
            pend[p] = 1'b1;
          end
        end
      end
      if (32'(rd_addr[p]) < ZERO_REGS) begin
        fwd[p]  = rf_data[p];
        pend[p] = 1'b0;
      end
    end
  end

  always_comb begin
    case (bus.data_sel)
      2'b10:   a_sel = bus.left_data;
      2'b01:   a_sel = bus.right_data;
      2'b11:   a_sel = bus.cp_data;
      default: a_sel = fwd[0];
    endcase
    b_sel = bus.sel_imm ? bus.imm : fwd[1];
  end

  assign swap   = bus.is_sub & bus.sel_imm;
  assign hazard = (pend[0] && (bus.data_sel == 2'b00)) || (pend[1] && !bus.sel_imm);
  assign cnt_d  = (hazard && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= '0;
      rdy_q  <= '1;
      late_q <= 1'b0;
      cnt_q  <= '0;
      for (int k = 0; k < FWD_DEPTH; k++) begin
        addr_q[k] <= '0;
        data_q[k] <= '0;
      end
    end else begin
      en_q   <= en_d;
      rdy_q  <= rdy_d;
      addr_q <= addr_d;
      data_q <= data_d;
      late_q <= late_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.operand_a    = swap ? b_sel : a_sel;
  assign bus.operand_b    = swap ? a_sel : b_sel;
  assign bus.store_data   = fwd[1];
  assign bus.port1_data   = fwd[0];
  assign bus.hazard_stall = hazard;
  assign bus.late_error   = late_q;
  assign bus.stall_count  = cnt_q;
endmodule
